// File: rtl/program_loader.sv
// program_loader
// Receives a byte stream (2-byte big-endian word count, then that many
// big-endian 32-bit words), writes each word into instruction memory at
// consecutive word addresses, and holds the CPU in reset until the whole
// image has been written. An oversized header parks the block in ERROR.

module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] MAX_WORDS = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_write_en,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  count_hi;
    logic [1:0]  byte_idx;
    logic [15:0] word_idx;
    logic [23:0] word_buf;

    logic        transfer;
    logic [15:0] header_count;
    logic [15:0] word_idx_inc;

    // Next-state and output decode; every output depends only on the
    // registered state, except that the write strobe is suppressed while
    // reset is asserted so an aborted WRITE never reaches the memory.
    always_comb begin
        byte_ready   = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
        transfer     = byte_ready && byte_valid;
        header_count = {count_hi, byte_in};
        word_idx_inc = word_idx + 16'd1;
        state_next   = state;
        mem_write_en = (state == WRITE) && !reset;
        done         = (state == DONE);
        error        = (state == ERROR);
        cpu_reset    = (state != DONE);

        case (state)
            LEN_HI: begin
                if (transfer) begin
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (transfer) begin
                    if (header_count == 16'd0) begin
                        state_next = DONE;
                    end else if (header_count > MAX_WORDS) begin
                        state_next = ERROR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (transfer && (byte_idx == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (word_idx_inc == word_count) begin
                    state_next = DONE;
                end else begin
                    state_next = DATA;
                end
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = LEN_HI;
        endcase
    end

    // State register; reset always wins over a simultaneous byte transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LEN_HI;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: header capture, word assembly, and the write address/data
    // registers, which are loaded on the last byte of a word so they are
    // valid throughout WRITE and simply hold afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_hi   <= 8'd0;
            word_count <= 16'd0;
            byte_idx   <= 2'd0;
            word_idx   <= 16'd0;
            word_buf   <= 24'd0;
            mem_addr   <= 32'd0;
            mem_data   <= 32'd0;
        end else begin
            case (state)
                LEN_HI: begin
                    if (transfer) begin
                        count_hi <= byte_in;
                    end
                end
                LEN_LO: begin
                    if (transfer) begin
                        word_count <= header_count;
                        byte_idx   <= 2'd0;
                        word_idx   <= 16'd0;
                    end
                end
                DATA: begin
                    if (transfer) begin
                        word_buf <= {word_buf[15:0], byte_in};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_data <= {word_buf, byte_in};
                            mem_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
// Drives directed and randomized program images into program_loader and
// compares the memory writes it produces against the list of (address,
// word) pairs computed directly from the byte stream.

module tb_program_loader;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam logic [15:0] MAXW = 16'd1024;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_write_en;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;
    int last_xfer = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cycle[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  stream[$];

    program_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_write_en(mem_write_en),
        .cpu_reset(cpu_reset),
        .done(done),
        .error(error),
        .word_count(word_count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time-stamp transfers and writes.
    always @(posedge clk) cycle <= cycle + 1;

    // Memory-side monitor: records every write strobe seen mid-cycle.
    always @(negedge clk) begin
        #1;
        if (mem_write_en === 1'b1) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_data);
            obs_cycle.push_back(cycle);
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cycle.delete();
    endtask

    // Offer one byte after a random idle gap and wait for it to be taken.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        waited = 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_in = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (byte_ready !== 1'b1) begin
            check_output("ready_timeout", {31'd0, byte_ready}, 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
            last_xfer = cycle;
        end
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        byte_valid = 1'b0;
    endtask

    // Expected writes straight from the stream format: header N, then N
    // big-endian words landing at BASE + 4*i (32-bit wrap).
    task automatic build_expected();
        int n;
        exp_addr.delete();
        exp_data.delete();
        if (stream.size() < 2) return;
        n = (int'(stream[0]) << 8) | int'(stream[1]);
        if (n == 0 || n > int'(MAXW)) return;
        for (int i = 0; i < n; i++) begin
            if (2 + 4 * i + 3 < stream.size()) begin
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back({stream[2+4*i], stream[3+4*i],
                                    stream[4+4*i], stream[5+4*i]});
            end
        end
    endtask

    task automatic check_writes(input string tag);
        int m;
        check_output({tag, "_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            check_output($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
            check_output($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
        end
    endtask

    task automatic make_stream(input int n);
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n & 8'hFF));
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic run_load(input string tag, input int max_gap);
        clear_obs();
        foreach (stream[i]) send_byte(stream[i], max_gap);
        idle(6);
        build_expected();
        check_writes(tag);
    endtask

    // Directed and randomized scenarios in sequence.
    initial begin
        int n;
        reset = 1'b1;
        byte_valid = 1'b0;
        byte_in = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check_output("rst_ready", {31'd0, byte_ready}, 32'd1);
        check_output("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_output("rst_done", {31'd0, done}, 32'd0);
        check_output("rst_error", {31'd0, error}, 32'd0);
        check_output("rst_wen", {31'd0, mem_write_en}, 32'd0);
        check_output("rst_addr", mem_addr, 32'd0);
        check_output("rst_data", mem_data, 32'd0);
        check_output("rst_count", {16'd0, word_count}, 32'd0);

        // Single word, back-to-back, with exact latency checks.
        clear_obs();
        stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (stream[i]) send_byte(stream[i], 0);
        #2;
        check_output("one_wen", {31'd0, mem_write_en}, 32'd1);
        check_output("one_addr", mem_addr, BASE);
        check_output("one_data", mem_data, 32'hDEADBEEF);
        check_output("one_ready_in_write", {31'd0, byte_ready}, 32'd0);
        check_output("one_done_early", {31'd0, done}, 32'd0);
        byte_valid = 1'b0;
        @(negedge clk);
        check_output("one_done", {31'd0, done}, 32'd1);
        check_output("one_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_output("one_wen_after", {31'd0, mem_write_en}, 32'd0);
        check_output("one_data_hold", mem_data, 32'hDEADBEEF);
        idle(4);
        check_output("one_nwrites", 32'(obs_addr.size()), 32'd1);
        if (obs_cycle.size() > 0)
            check_output("one_latency", 32'(obs_cycle[0]), 32'(last_xfer));

        // Three words with random gaps; addresses wrap past 2^32.
        do_reset();
        make_stream(3);
        run_load("three", 3);
        check_output("three_done", {31'd0, done}, 32'd1);
        check_output("three_count", {16'd0, word_count}, 32'd3);
        byte_valid = 1'b1;
        repeat (6) begin
            byte_in = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check_output("three_no_more_writes", 32'(obs_addr.size()), 32'd3);
        check_output("three_done_holds", {31'd0, done}, 32'd1);

        // Empty image.
        do_reset();
        stream = '{8'h00, 8'h00};
        run_load("empty", 2);
        check_output("empty_done", {31'd0, done}, 32'd1);
        check_output("empty_count", {16'd0, word_count}, 32'd0);
        check_output("empty_cpu_reset", {31'd0, cpu_reset}, 32'd0);

        // One word over the limit.
        do_reset();
        stream = '{8'h04, 8'h01};
        run_load("over", 2);
        check_output("over_error", {31'd0, error}, 32'd1);
        check_output("over_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_output("over_ready", {31'd0, byte_ready}, 32'd0);
        check_output("over_done", {31'd0, done}, 32'd0);
        byte_valid = 1'b1;
        repeat (6) begin
            byte_in = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check_output("over_no_writes", 32'(obs_addr.size()), 32'd0);

        // Exactly at the limit is accepted.
        do_reset();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        idle(3);
        check_output("limit_error", {31'd0, error}, 32'd0);
        check_output("limit_ready", {31'd0, byte_ready}, 32'd1);
        check_output("limit_count", {16'd0, word_count}, 32'd1024);

        // Reset beats a simultaneous transfer of a zero low count byte.
        do_reset();
        send_byte(8'h00, 0);
        byte_in = 8'h00;
        byte_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        byte_valid = 1'b0;
        idle(2);
        check_output("prio_done", {31'd0, done}, 32'd0);
        check_output("prio_ready", {31'd0, byte_ready}, 32'd1);

        // Abort mid-word, then a fresh load.
        do_reset();
        clear_obs();
        make_stream(2);
        for (int i = 0; i < 8; i++) send_byte(stream[i], 1);
        do_reset();
        idle(2);
        check_output("abort_nwrites", 32'(obs_addr.size()), 32'd1);
        if (obs_data.size() > 0)
            check_output("abort_word0", obs_data[0],
                         {stream[2], stream[3], stream[4], stream[5]});
        check_output("abort_ready", {31'd0, byte_ready}, 32'd1);
        check_output("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_output("abort_done", {31'd0, done}, 32'd0);
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load("fresh", 0);
        check_output("fresh_done", {31'd0, done}, 32'd1);

        // Reset landing in the WRITE cycle suppresses the write.
        do_reset();
        clear_obs();
        make_stream(1);
        foreach (stream[i]) send_byte(stream[i], 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        byte_valid = 1'b0;
        idle(3);
        check_output("midwrite_nwrites", 32'(obs_addr.size()), 32'd0);
        check_output("midwrite_done", {31'd0, done}, 32'd0);

        // Randomized images with random gaps (including none).
        for (int k = 0; k < 4; k++) begin
            do_reset();
            n = int'($urandom_range(6, 1));
            make_stream(n);
            run_load($sformatf("rand%0d", k), int'($urandom_range(3, 0)));
            check_output($sformatf("rand%0d_done", k), {31'd0, done}, 32'd1);
            check_output($sformatf("rand%0d_wc", k), {16'd0, word_count}, 32'(n));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; word-aligned.
REQ-002 Parameter: MAX_WORDS, 16'd1024, largest accepted word count.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: byte_in  in  8  incoming program byte.
REQ-006 Port: byte_valid  in  1  byte_in holds a valid byte.
REQ-007 Port: byte_ready  out  1  loader can accept a byte; a transfer occurs when byte_valid and byte_ready are both high on a clock edge.
REQ-008 Port: mem_addr  out  32  byte address of the instruction-memory write.
REQ-009 Port: mem_data  out  32  instruction word to write.
REQ-010 Port: mem_write_en  out  1  one-cycle write strobe into instruction memory.
REQ-011 Port: cpu_reset  out  1  holds the CPU in reset until the load completes.
REQ-012 Port: done  out  1  load completed successfully.
REQ-013 Port: error  out  1  header rejected.
REQ-014 Port: word_count  out  16  latched header word count.

Function
REQ-015 Stream format: 2-byte big-endian word count N, then N words of 4 bytes each, each word big-endian (MSB first).
REQ-016 States: LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
REQ-017 byte_ready SHALL be 1 in LEN_HI, LEN_LO and DATA, and 0 in WRITE, DONE and ERROR; state is decoded from registers only, with no combinational path from byte_valid.
REQ-018 LEN_HI: on transfer, latch count[15:8] and go to LEN_LO.
REQ-019 LEN_LO: on transfer, set word_count = {count[15:8], byte_in}.
- If the value is 0: go to DONE.
- If the value exceeds MAX_WORDS: go to ERROR.
- Otherwise: go to DATA with byte_idx=0 and word_idx=0.
REQ-020 DATA: on each transfer, shift in the byte (word <= {word[23:0], byte_in}) and increment byte_idx; the transfer with byte_idx==3 moves to WRITE and wraps byte_idx to 0.
REQ-021 WRITE lasts exactly one cycle with the following outputs:
- mem_write_en=1
- mem_data = assembled word
- mem_addr = BASE_ADDR + 4*word_idx, with 32-bit arithmetic that wraps modulo 2^32
REQ-022 Leaving WRITE: increment word_idx; go to DONE if the new word_idx equals word_count, otherwise go to DATA.
REQ-023 mem_write_en SHALL be 0 in every state except WRITE; mem_addr and mem_data hold their last values outside WRITE.
REQ-024 DONE: done=1 and cpu_reset=0; remain in DONE until reset; ignore byte_valid.
REQ-025 ERROR: error=1 and cpu_reset=1; remain in ERROR until reset; perform no memory writes.
REQ-026 cpu_reset SHALL be 1 in every state other than DONE.
REQ-027 byte_valid is ignored whenever byte_ready=0; no byte is consumed or lost in WRITE, because the source must hold the byte until a transfer occurs.
REQ-028 Gaps of any length between bytes SHALL be tolerated with no timeout; byte_valid=0 causes no state change.
REQ-029 Latency: the write strobe occurs in the cycle immediately after the 4th byte transfer of a word; done rises in the cycle after the final WRITE.

Reset
REQ-030 When reset=1 on a clock edge, the block SHALL enter LEN_HI and drive the following values:
- byte_idx=0, word_idx=0, word_count=0
- mem_write_en=0, mem_addr=0, mem_data=0
- done=0, error=0
- cpu_reset=1, byte_ready=1 (from the following cycle)
REQ-031 Reset asserted in any state, including mid-word and mid-WRITE, SHALL abort the load; the next clock edge performs no write, and previously written memory is left unchanged.
REQ-032 Reset SHALL take priority over a simultaneous byte transfer, and the byte is discarded.

Verification
REQ-033 Bytes 00 01 DE AD BE EF sent back-to-back -> one write with mem_addr=BASE_ADDR and mem_data=32'hDEADBEEF, one cycle after the 4th data byte; done=1 and cpu_reset=0 on the next cycle.
REQ-034 Header 00 03 followed by 12 bytes with random byte_valid gaps -> 3 writes at BASE_ADDR, +4 and +8 with the correct words; no writes after done.
REQ-035 Header 00 00 -> DONE directly; zero writes; word_count=0; cpu_reset=0.
REQ-036 Header 04 01 with MAX_WORDS=1024 -> error=1 and cpu_reset=1; byte_ready=0 afterwards; no writes.
REQ-037 Header 00 02, one full word, then 2 bytes, then reset -> exactly one write observed; after reset the block is in LEN_HI with byte_ready=1, cpu_reset=1, done=0; a fresh 00 01 11 22 33 44 load writes 32'h11223344 at BASE_ADDR.
REQ-038 byte_valid held at 1 continuously through WRITE -> the byte present during WRITE is not consumed until DATA; the assembled words match the stream exactly.
